// File: rtl/tetris_btn_cond.sv
// Push-button conditioning for the game core: 2-flop sync, debounce, one-cycle press pulses.
// Define TETRIS_BTN_REPEAT_EN to add DAS-style auto-repeat on the left, right and down buttons.
module tetris_btn_cond #(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 8000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    input  logic       btnS,
    output logic       pL,
    output logic       pR,
    output logic       pD,
    output logic       pS,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // Bit order everywhere is {S, D, R, L}
    logic [3:0] w_raw;
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] w_st;
    logic [3:0] w_rise;
    logic [3:0] w_ev;

    assign w_raw = {btnS, btnD, btnR, btnL};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic             r_st;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_st  <= 1'b0;
                r_cnt <= '0;
            end else if (r_s2[g] == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_st  <= r_s2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_st[g]   = r_st;
        // Rise is flagged on the same edge that commits the new level
        assign w_rise[g] = r_s2[g] & ~r_st & (r_cnt == DB_LAST);
    end

`ifdef TETRIS_BTN_REPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    for (genvar g = 0; g < 3; g++) begin : g_rep
        rep_state_t       r_state;
        rep_state_t       w_state_nx;
        logic [CNT_W-1:0] r_rc;
        logic [CNT_W-1:0] w_rc_nx;
        logic             w_pulse;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= IDLE;
                r_rc    <= '0;
            end else begin
                r_state <= w_state_nx;
                r_rc    <= w_rc_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_rc_nx    = r_rc + CNT_W'(1);
            w_pulse    = 1'b0;
            case (r_state)
                IDLE: begin
                    w_rc_nx = '0;
                    if (w_rise[g]) begin
                        w_pulse    = 1'b1;
                        w_state_nx = DELAY;
                    end
                end
                DELAY: begin
                    if (!w_st[g]) begin
                        w_state_nx = IDLE;
                        w_rc_nx    = '0;
                    end else if (r_rc == RD_LAST) begin
                        w_pulse    = 1'b1;
                        w_state_nx = REPEAT;
                        w_rc_nx    = '0;
                    end
                end
                REPEAT: begin
                    if (!w_st[g]) begin
                        w_state_nx = IDLE;
                        w_rc_nx    = '0;
                    end else if (r_rc == RP_LAST) begin
                        w_pulse = 1'b1;
                        w_rc_nx = '0;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_rc_nx    = '0;
                end
            endcase
        end

        assign w_ev[g] = w_pulse;
    end

    assign w_ev[3] = w_rise[3];
`else
    // REPEAT_* have no effect in the press-only build
    logic w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_ev = w_rise;
`endif

    // Simultaneous left and right events cancel each other
    always_ff @(posedge clk) begin
        if (rst) begin
            pL <= 1'b0;
            pR <= 1'b0;
            pD <= 1'b0;
            pS <= 1'b0;
        end else begin
            pL <= w_ev[0] & ~w_ev[1];
            pR <= w_ev[1] & ~w_ev[0];
            pD <= w_ev[2];
            pS <= w_ev[3];
        end
    end

    assign held = w_st;

endmodule
